// File: rtl/assoc_buffer_pkg.sv
// Shared definitions for the associative buffer: command encodings.
//   CTRL_LOOKUP  2'b00  read the value stored under a key
//   CTRL_LOAD    2'b01  write a value (update on hit, allocate on miss)
//   CTRL_INCR    2'b10  add one to the value stored under a key
//   CTRL_DELETE  2'b11  invalidate the entry holding a key
package assoc_buffer_pkg;

  localparam int unsigned CTRL_W = 2;

  typedef enum logic [CTRL_W-1:0] {
    CTRL_LOOKUP = 2'b00,
    CTRL_LOAD   = 2'b01,
    CTRL_INCR   = 2'b10,
    CTRL_DELETE = 2'b11
  } ctrl_e;

endpackage

// File: rtl/assoc_buffer_entry.sv
// One storage slot of the associative buffer: valid bit, key and data
// registers, plus a combinational key-match flag.
// Ports:
//   clk, rst       clock, synchronous active-high reset (clears the slot)
//   key            key being searched / written
//   set_en         write slot: vld=1, key_q=key, data_q=set_data
//   set_data       data written when set_en is high
//   clr_en         invalidate slot (ignored when set_en is high)
//   match_c        slot is valid and holds 'key' (combinational)
//   vld            registered valid bit
//   data           registered stored value
module assoc_buffer_entry #(
  parameter int unsigned KEY_WIDTH  = 2,
  parameter int unsigned DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [KEY_WIDTH-1:0]  key,
  input  logic                  set_en,
  input  logic [DATA_WIDTH-1:0] set_data,
  input  logic                  clr_en,
  output logic                  match_c,
  output logic                  vld,
  output logic [DATA_WIDTH-1:0] data
);

  logic                  vld_q,  vld_d;
  logic [KEY_WIDTH-1:0]  key_q,  key_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  // Next-state for the slot registers.
  always_comb begin
    vld_d  = vld_q;
    key_d  = key_q;
    data_d = data_q;
    if (set_en) begin
      vld_d  = 1'b1;
      key_d  = key;
      data_d = set_data;
    end else if (clr_en) begin
      vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      key_q  <= '0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      key_q  <= key_d;
      data_q <= data_d;
    end
  end

  assign match_c = vld_q && (key_q == key);
  assign vld     = vld_q;
  assign data    = data_q;

endmodule

// File: rtl/associative_buffer.sv
// Small fully-associative key/value store with DEPTH entries. One command
// per clock (LOOKUP/LOAD/INCR/DELETE); result registered one cycle later.
// Optional build macro: ASSOC_BUF_SATURATE_EN -- INCR saturates at all-ones
// instead of wrapping to zero.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   ctrl           command (see assoc_buffer_pkg::ctrl_e)
//   key            key addressed by the command
//   data_input     value for LOAD
//   data_output    value of addressed entry after the command (registered)
//   valid          command hit/succeeded (registered)
module associative_buffer
  import assoc_buffer_pkg::*;
#(
  parameter int unsigned KEY_WIDTH  = 2,
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CTRL_W-1:0]     ctrl,
  input  logic [KEY_WIDTH-1:0]  key,
  input  logic [DATA_WIDTH-1:0] data_input,
  output logic [DATA_WIDTH-1:0] data_output,
  output logic                  valid
);

  logic [DEPTH-1:0]      match;
  logic [DEPTH-1:0]      ent_vld;
  logic [DATA_WIDTH-1:0] ent_data [DEPTH];
  logic [DEPTH-1:0]      set_en;
  logic [DEPTH-1:0]      clr_en;
  logic [DATA_WIDTH-1:0] set_data;

  logic                  hit;
  logic [DATA_WIDTH-1:0] hit_data;
  logic [DEPTH-1:0]      alloc_oh;
  logic                  any_free;
  logic [DATA_WIDTH-1:0] incr_val;

  logic [DATA_WIDTH-1:0] data_output_q, data_output_d;
  logic                  valid_q,       valid_d;

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    assoc_buffer_entry #(
      .KEY_WIDTH  (KEY_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_entry (
      .clk      (clk),
      .rst      (rst),
      .key      (key),
      .set_en   (set_en[i]),
      .set_data (set_data),
      .clr_en   (clr_en[i]),
      .match_c  (match[i]),
      .vld      (ent_vld[i]),
      .data     (ent_data[i])
    );
  end

  // Keys are unique, so match is one-hot and an AND-OR mux suffices.
  always_comb begin
    hit      = |match;
    hit_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (match[i]) hit_data = hit_data | ent_data[i];
    end
  end

  // Lowest-index free slot, one-hot.
  always_comb begin
    alloc_oh = '0;
    any_free = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!ent_vld[i] && !any_free) begin
        alloc_oh[i] = 1'b1;
        any_free    = 1'b1;
      end
    end
  end

  // Incremented value of the hit entry.
  always_comb begin
`ifdef ASSOC_BUF_SATURATE_EN
    if (&hit_data) incr_val = hit_data;
    else           incr_val = hit_data + DATA_WIDTH'(1);
`else
    incr_val = hit_data + DATA_WIDTH'(1);
`endif
  end

  // Command decode: entry write/clear strobes and next outputs.
  // Unrecognised (e.g. unknown) ctrl falls to default: no state change.
  always_comb begin
    set_en        = '0;
    clr_en        = '0;
    set_data      = data_input;
    data_output_d = '0;
    valid_d       = 1'b0;
    case (ctrl_e'(ctrl))
      CTRL_LOOKUP: begin
        if (hit) begin
          data_output_d = hit_data;
          valid_d       = 1'b1;
        end
      end
      CTRL_LOAD: begin
        if (hit || any_free) begin
          set_en        = hit ? match : alloc_oh;
          data_output_d = data_input;
          valid_d       = 1'b1;
        end
      end
      CTRL_INCR: begin
        if (hit) begin
          set_data      = incr_val;
          set_en        = match;
          data_output_d = incr_val;
          valid_d       = 1'b1;
        end
      end
      CTRL_DELETE: begin
        if (hit) begin
          clr_en        = match;
          data_output_d = hit_data;
          valid_d       = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_output_q <= '0;
      valid_q       <= 1'b0;
    end else begin
      data_output_q <= data_output_d;
      valid_q       <= valid_d;
    end
  end

  assign data_output = data_output_q;
  assign valid       = valid_q;

endmodule

// File: tb/tb_associative_buffer.sv
// Directed bench for associative_buffer: a DEPTH=4 instance for the main
// command set and a DEPTH=2 instance for the full-buffer cases. Both share
// the same stimulus.
module tb_associative_buffer;

  localparam logic [1:0] C_LOOKUP = 2'b00;
  localparam logic [1:0] C_LOAD   = 2'b01;
  localparam logic [1:0] C_INCR   = 2'b10;
  localparam logic [1:0] C_DELETE = 2'b11;

`ifdef ASSOC_BUF_SATURATE_EN
  localparam logic [3:0] WRAP_VAL = 4'hF;
`else
  localparam logic [3:0] WRAP_VAL = 4'h0;
`endif

  logic       clk;
  logic       rst;
  logic [1:0] ctrl;
  logic [1:0] key;
  logic [3:0] din;
  logic [3:0] dout4, dout2;
  logic       valid4, valid2;

  int checks   = 0;
  int failures = 0;

  associative_buffer #(.KEY_WIDTH(2), .DATA_WIDTH(4), .DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .ctrl(ctrl), .key(key),
    .data_input(din), .data_output(dout4), .valid(valid4)
  );

  associative_buffer #(.KEY_WIDTH(2), .DATA_WIDTH(4), .DEPTH(2)) dut2 (
    .clk(clk), .rst(rst), .ctrl(ctrl), .key(key),
    .data_input(din), .data_output(dout2), .valid(valid2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one command, clock it, sample 1 ns after the edge.
  task automatic step(input logic [1:0] c, input logic [1:0] k, input logic [3:0] d);
    ctrl = c;
    key  = k;
    din  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(C_LOOKUP, 2'd1, 4'h0);
    step(C_LOOKUP, 2'd1, 4'h0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({valid4, dout4} !== 5'b0_0000) begin
      failures++; $display("FAIL reset_d4 got=%b_%h exp=0_0", valid4, dout4);
    end
    checks++;
    if ({valid2, dout2} !== 5'b0_0000) begin
      failures++; $display("FAIL reset_d2 got=%b_%h exp=0_0", valid2, dout2);
    end
    step(C_LOOKUP, 2'd1, 4'h0);
    checks++;
    if ({valid4, dout4} !== 5'b0_0000) begin
      failures++; $display("FAIL reset_lookup got=%b_%h exp=0_0", valid4, dout4);
    end
  endtask

  task automatic test_load_lookup();
    step(C_LOAD, 2'd1, 4'hE);
    checks++;
    if ({valid4, dout4} !== {1'b1, 4'hE}) begin
      failures++; $display("FAIL load_k1 got=%b_%h exp=1_e", valid4, dout4);
    end
    step(C_LOOKUP, 2'd1, 4'h0);
    checks++;
    if ({valid4, dout4} !== {1'b1, 4'hE}) begin
      failures++; $display("FAIL lookup_k1 got=%b_%h exp=1_e", valid4, dout4);
    end
    // Idle cycle: outputs recomputed, not held.
    step(C_LOOKUP, 2'd3, 4'h0);
    checks++;
    if ({valid4, dout4} !== 5'b0_0000) begin
      failures++; $display("FAIL lookup_k3_miss got=%b_%h exp=0_0", valid4, dout4);
    end
  endtask

  task automatic test_incr_wrap();
    step(C_INCR, 2'd1, 4'h0);
    checks++;
    if ({valid4, dout4} !== {1'b1, 4'hF}) begin
      failures++; $display("FAIL incr1 got=%b_%h exp=1_f", valid4, dout4);
    end
    step(C_INCR, 2'd1, 4'h0);
    checks++;
    if ({valid4, dout4} !== {1'b1, WRAP_VAL}) begin
      failures++; $display("FAIL incr2_wrap got=%b_%h exp=1_%h", valid4, dout4, WRAP_VAL);
    end
  endtask

  task automatic test_miss();
    step(C_INCR, 2'd2, 4'h0);
    checks++;
    if ({valid4, dout4} !== 5'b0_0000) begin
      failures++; $display("FAIL incr_miss got=%b_%h exp=0_0", valid4, dout4);
    end
    step(C_LOOKUP, 2'd2, 4'h0);
    checks++;
    if ({valid4, dout4} !== 5'b0_0000) begin
      failures++; $display("FAIL lookup_miss got=%b_%h exp=0_0", valid4, dout4);
    end
    step(C_DELETE, 2'd2, 4'h0);
    checks++;
    if ({valid4, dout4} !== 5'b0_0000) begin
      failures++; $display("FAIL delete_miss got=%b_%h exp=0_0", valid4, dout4);
    end
    step(C_LOOKUP, 2'd1, 4'h0);
    checks++;
    if ({valid4, dout4} !== {1'b1, WRAP_VAL}) begin
      failures++; $display("FAIL k1_unchanged got=%b_%h exp=1_%h", valid4, dout4, WRAP_VAL);
    end
  endtask

  task automatic test_full_depth2();
    do_reset();
    step(C_LOAD, 2'd0, 4'h3);
    checks++;
    if ({valid2, dout2} !== {1'b1, 4'h3}) begin
      failures++; $display("FAIL d2_load_k0 got=%b_%h exp=1_3", valid2, dout2);
    end
    step(C_LOAD, 2'd1, 4'h5);
    checks++;
    if ({valid2, dout2} !== {1'b1, 4'h5}) begin
      failures++; $display("FAIL d2_load_k1 got=%b_%h exp=1_5", valid2, dout2);
    end
    step(C_LOAD, 2'd2, 4'h7);
    checks++;
    if ({valid2, dout2} !== 5'b0_0000) begin
      failures++; $display("FAIL d2_load_full got=%b_%h exp=0_0", valid2, dout2);
    end
    // Same load on the 4-deep instance has room.
    checks++;
    if ({valid4, dout4} !== {1'b1, 4'h7}) begin
      failures++; $display("FAIL d4_load_k2 got=%b_%h exp=1_7", valid4, dout4);
    end
    step(C_LOAD, 2'd1, 4'h9);
    checks++;
    if ({valid2, dout2} !== {1'b1, 4'h9}) begin
      failures++; $display("FAIL d2_load_hit got=%b_%h exp=1_9", valid2, dout2);
    end
    step(C_LOOKUP, 2'd1, 4'h0);
    checks++;
    if ({valid2, dout2} !== {1'b1, 4'h9}) begin
      failures++; $display("FAIL d2_lookup_k1 got=%b_%h exp=1_9", valid2, dout2);
    end
    step(C_DELETE, 2'd0, 4'h0);
    checks++;
    if ({valid2, dout2} !== {1'b1, 4'h3}) begin
      failures++; $display("FAIL d2_delete_k0 got=%b_%h exp=1_3", valid2, dout2);
    end
    step(C_LOOKUP, 2'd0, 4'h0);
    checks++;
    if ({valid2, dout2} !== 5'b0_0000) begin
      failures++; $display("FAIL d2_lookup_deleted got=%b_%h exp=0_0", valid2, dout2);
    end
    step(C_LOAD, 2'd2, 4'h7);
    checks++;
    if ({valid2, dout2} !== {1'b1, 4'h7}) begin
      failures++; $display("FAIL d2_load_k2_retry got=%b_%h exp=1_7", valid2, dout2);
    end
    step(C_LOOKUP, 2'd2, 4'h0);
    checks++;
    if ({valid2, dout2} !== {1'b1, 4'h7}) begin
      failures++; $display("FAIL d2_lookup_k2 got=%b_%h exp=1_7", valid2, dout2);
    end
    step(C_LOOKUP, 2'd1, 4'h0);
    checks++;
    if ({valid2, dout2} !== {1'b1, 4'h9}) begin
      failures++; $display("FAIL d2_k1_kept got=%b_%h exp=1_9", valid2, dout2);
    end
  endtask

  task automatic test_reset_priority();
    rst = 1'b1;
    step(C_LOAD, 2'd3, 4'hA);
    rst = 1'b0;
    checks++;
    if ({valid4, dout4} !== 5'b0_0000) begin
      failures++; $display("FAIL rst_load_out got=%b_%h exp=0_0", valid4, dout4);
    end
    step(C_LOOKUP, 2'd3, 4'h0);
    checks++;
    if ({valid4, dout4} !== 5'b0_0000) begin
      failures++; $display("FAIL rst_load_nowrite got=%b_%h exp=0_0", valid4, dout4);
    end
    step(C_LOOKUP, 2'd2, 4'h0);
    checks++;
    if ({valid4, dout4} !== 5'b0_0000) begin
      failures++; $display("FAIL rst_cleared_k2 got=%b_%h exp=0_0", valid4, dout4);
    end
  endtask

  task automatic test_back_to_back();
    step(C_LOAD, 2'd0, 4'h1);
    checks++;
    if ({valid4, dout4} !== {1'b1, 4'h1}) begin
      failures++; $display("FAIL b2b_load got=%b_%h exp=1_1", valid4, dout4);
    end
    step(C_INCR, 2'd0, 4'h0);
    checks++;
    if ({valid4, dout4} !== {1'b1, 4'h2}) begin
      failures++; $display("FAIL b2b_incr got=%b_%h exp=1_2", valid4, dout4);
    end
    step(C_DELETE, 2'd0, 4'h0);
    checks++;
    if ({valid4, dout4} !== {1'b1, 4'h2}) begin
      failures++; $display("FAIL b2b_delete got=%b_%h exp=1_2", valid4, dout4);
    end
    step(C_INCR, 2'd0, 4'h0);
    checks++;
    if ({valid4, dout4} !== 5'b0_0000) begin
      failures++; $display("FAIL b2b_incr_deleted got=%b_%h exp=0_0", valid4, dout4);
    end
    step(C_LOAD, 2'd0, 4'h5);
    checks++;
    if ({valid4, dout4} !== {1'b1, 4'h5}) begin
      failures++; $display("FAIL b2b_reload got=%b_%h exp=1_5", valid4, dout4);
    end
    step(C_LOOKUP, 2'd0, 4'h0);
    checks++;
    if ({valid4, dout4} !== {1'b1, 4'h5}) begin
      failures++; $display("FAIL b2b_lookup got=%b_%h exp=1_5", valid4, dout4);
    end
  endtask

  initial begin
    rst  = 1'b0;
    ctrl = 2'bxx;
    key  = 2'bxx;
    din  = 4'bxxxx;
    @(posedge clk);
    #1;
    test_reset();
    test_load_lookup();
    test_incr_wrap();
    test_miss();
    test_full_depth2();
    test_reset_priority();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
